// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  // x0 is hardwired zero, so a load targeting it never creates a hazard.
  localparam logic [4:0]  REG_ZERO = 5'd0;
  // Canonical NOP (addi x0,x0,0) loaded by a bubbled stage register.
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use comparator: the load in E writes a register the instruction in D reads.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       use_rs1,
  input  logic       use_rs2,
  input  logic [4:0] rd,
  input  logic       is_load,
  output logic       hit
);

  logic rd_live;

  // A hit needs a real destination and a matching, actually-read source.
  always_comb begin
    rd_live = is_load && (rd != REG_ZERO);
    hit     = rd_live && ((use_rs1 && (rs1 == rd)) || (use_rs2 && (rs2 == rd)));
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central five-stage pipeline controller: hazard arbitration, trap drain,
// ebreak halt and stall/flush performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_i_busy,
  input  logic [4:0]       dec_i_rs1,
  input  logic [4:0]       dec_i_rs2,
  input  logic             dec_i_use_rs1,
  input  logic             dec_i_use_rs2,
  input  logic [4:0]       exe_i_rd,
  input  logic             exe_i_is_load,
  input  logic             exe_i_mdu_busy,
  input  logic             exe_i_redirect,
  input  logic [XLEN-1:0]  exe_i_redirect_pc,
  input  logic             mem_i_busy,
  input  logic             wb_i_trap,
  input  logic [XLEN-1:0]  wb_i_trap_vec,
  input  logic             wb_i_ebreak,
  output logic             ctrl_o_stall_f,
  output logic             ctrl_o_stall_d,
  output logic             ctrl_o_stall_e,
  output logic             ctrl_o_stall_m,
  output logic             ctrl_o_bubble_d,
  output logic             ctrl_o_bubble_e,
  output logic             ctrl_o_bubble_m,
  output logic             ctrl_o_bubble_w,
  output logic             ctrl_o_redirect,
  output logic [XLEN-1:0]  ctrl_o_redirect_pc,
  output logic             ctrl_o_halted,
  output logic [CNT_W-1:0] ctrl_o_cnt_mem,
  output logic [CNT_W-1:0] ctrl_o_cnt_hazard,
  output logic [CNT_W-1:0] ctrl_o_cnt_flush
);

  state_t          state_q, state_d;
  logic [XLEN-1:0] trap_pc_q;
  logic            lu_hit;
  logic            inc_mem, inc_hazard, inc_flush, latch_vec;

  hazard_detect u_hazard (
    .rs1     (dec_i_rs1),
    .rs2     (dec_i_rs2),
    .use_rs1 (dec_i_use_rs1),
    .use_rs2 (dec_i_use_rs2),
    .rd      (exe_i_rd),
    .is_load (exe_i_is_load),
    .hit     (lu_hit)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_RUN;
    else      state_q <= state_d;
  end

  // Next state: ebreak halts for good, a trap stuck behind memory drains first.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (wb_i_ebreak)                  state_d = ST_HALT;
        else if (wb_i_trap && mem_i_busy) state_d = ST_DRAIN;
      end
      ST_DRAIN: if (!mem_i_busy) state_d = ST_RUN;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_RUN;
    endcase
  end

  // Outputs: priority-ordered hazard arbitration; stall and bubble never share a stage.
  always_comb begin
    ctrl_o_stall_f     = 1'b0;
    ctrl_o_stall_d     = 1'b0;
    ctrl_o_stall_e     = 1'b0;
    ctrl_o_stall_m     = 1'b0;
    ctrl_o_bubble_d    = 1'b0;
    ctrl_o_bubble_e    = 1'b0;
    ctrl_o_bubble_m    = 1'b0;
    ctrl_o_bubble_w    = 1'b0;
    ctrl_o_redirect    = 1'b0;
    ctrl_o_redirect_pc = '0;
    ctrl_o_halted      = 1'b0;
    inc_mem            = 1'b0;
    inc_hazard         = 1'b0;
    inc_flush          = 1'b0;
    latch_vec          = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (wb_i_ebreak) begin
          ctrl_o_stall_f = 1'b1;
          {ctrl_o_bubble_d, ctrl_o_bubble_e, ctrl_o_bubble_m, ctrl_o_bubble_w} = 4'b1111;
        end else if (wb_i_trap) begin
          {ctrl_o_bubble_d, ctrl_o_bubble_e, ctrl_o_bubble_m, ctrl_o_bubble_w} = 4'b1111;
          inc_flush = 1'b1;
          if (mem_i_busy) begin
            ctrl_o_stall_f = 1'b1;
            latch_vec      = 1'b1;
          end else begin
            ctrl_o_redirect    = 1'b1;
            ctrl_o_redirect_pc = wb_i_trap_vec;
          end
        end else if (mem_i_busy) begin
          {ctrl_o_stall_f, ctrl_o_stall_d, ctrl_o_stall_e, ctrl_o_stall_m} = 4'b1111;
          ctrl_o_bubble_w = 1'b1;
          inc_mem         = 1'b1;
        end else if (exe_i_mdu_busy) begin
          {ctrl_o_stall_f, ctrl_o_stall_d, ctrl_o_stall_e} = 3'b111;
          ctrl_o_bubble_m = 1'b1;
          inc_hazard      = 1'b1;
        end else if (exe_i_redirect) begin
          ctrl_o_bubble_d    = 1'b1;
          ctrl_o_bubble_e    = 1'b1;
          ctrl_o_redirect    = 1'b1;
          ctrl_o_redirect_pc = exe_i_redirect_pc;
          inc_flush          = 1'b1;
        end else if (lu_hit) begin
          ctrl_o_stall_f  = 1'b1;
          ctrl_o_stall_d  = 1'b1;
          ctrl_o_bubble_e = 1'b1;
          inc_hazard      = 1'b1;
        end else if (fetch_i_busy) begin
          ctrl_o_bubble_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        ctrl_o_stall_f = 1'b1;
        {ctrl_o_bubble_d, ctrl_o_bubble_e, ctrl_o_bubble_m, ctrl_o_bubble_w} = 4'b1111;
        if (!mem_i_busy) begin
          ctrl_o_redirect    = 1'b1;
          ctrl_o_redirect_pc = trap_pc_q;
        end
      end
      ST_HALT: begin
        ctrl_o_stall_f = 1'b1;
        {ctrl_o_bubble_d, ctrl_o_bubble_e, ctrl_o_bubble_m, ctrl_o_bubble_w} = 4'b1111;
        ctrl_o_halted = 1'b1;
      end
      default: ;
    endcase
  end

  // Trap vector held while the pipeline waits for memory to go idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           trap_pc_q <= '0;
    else if (latch_vec) trap_pc_q <= wb_i_trap_vec;
  end

  // Performance counters; they wrap naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_o_cnt_mem    <= '0;
      ctrl_o_cnt_hazard <= '0;
      ctrl_o_cnt_flush  <= '0;
    end else begin
      if (inc_mem)    ctrl_o_cnt_mem    <= ctrl_o_cnt_mem + 1'b1;
      if (inc_hazard) ctrl_o_cnt_hazard <= ctrl_o_cnt_hazard + 1'b1;
      if (inc_flush)  ctrl_o_cnt_flush  <= ctrl_o_cnt_flush + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: vector table for single-cycle arbitration,
// hand sequences for drain, halt and reset.
module tb_pipe_ctrl;

  localparam int XLEN  = 64;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             fetch_i_busy;
  logic [4:0]       dec_i_rs1, dec_i_rs2;
  logic             dec_i_use_rs1, dec_i_use_rs2;
  logic [4:0]       exe_i_rd;
  logic             exe_i_is_load, exe_i_mdu_busy, exe_i_redirect;
  logic [XLEN-1:0]  exe_i_redirect_pc;
  logic             mem_i_busy, wb_i_trap, wb_i_ebreak;
  logic [XLEN-1:0]  wb_i_trap_vec;
  logic             stall_f, stall_d, stall_e, stall_m;
  logic             bubble_d, bubble_e, bubble_m, bubble_w;
  logic             redirect, halted;
  logic [XLEN-1:0]  redirect_pc;
  logic [CNT_W-1:0] cnt_mem, cnt_hazard, cnt_flush;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .fetch_i_busy(fetch_i_busy),
    .dec_i_rs1(dec_i_rs1), .dec_i_rs2(dec_i_rs2),
    .dec_i_use_rs1(dec_i_use_rs1), .dec_i_use_rs2(dec_i_use_rs2),
    .exe_i_rd(exe_i_rd), .exe_i_is_load(exe_i_is_load),
    .exe_i_mdu_busy(exe_i_mdu_busy), .exe_i_redirect(exe_i_redirect),
    .exe_i_redirect_pc(exe_i_redirect_pc),
    .mem_i_busy(mem_i_busy), .wb_i_trap(wb_i_trap),
    .wb_i_trap_vec(wb_i_trap_vec), .wb_i_ebreak(wb_i_ebreak),
    .ctrl_o_stall_f(stall_f), .ctrl_o_stall_d(stall_d),
    .ctrl_o_stall_e(stall_e), .ctrl_o_stall_m(stall_m),
    .ctrl_o_bubble_d(bubble_d), .ctrl_o_bubble_e(bubble_e),
    .ctrl_o_bubble_m(bubble_m), .ctrl_o_bubble_w(bubble_w),
    .ctrl_o_redirect(redirect), .ctrl_o_redirect_pc(redirect_pc),
    .ctrl_o_halted(halted),
    .ctrl_o_cnt_mem(cnt_mem), .ctrl_o_cnt_hazard(cnt_hazard),
    .ctrl_o_cnt_flush(cnt_flush)
  );

  typedef struct {
    string       nm;
    logic        fb;
    logic [4:0]  rs1, rs2;
    logic        u1, u2;
    logic [4:0]  rd;
    logic        ld, mdu, rdr;
    logic [63:0] rpc;
    logic        mb, tr;
    logic [63:0] tv;
    logic [3:0]  e_stall;   // {f,d,e,m}
    logic [3:0]  e_bubble;  // {d,e,m,w}
    logic        e_redir;
    logic [63:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string nm, input logic fb,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic u1, input logic u2, input logic [4:0] rd,
                              input logic ld, input logic mdu, input logic rdr,
                              input logic [63:0] rpc, input logic mb, input logic tr,
                              input logic [63:0] tv, input logic [3:0] es,
                              input logic [3:0] eb, input logic er, input logic [63:0] epc);
    vec_t v;
    v.nm = nm; v.fb = fb; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
    v.rd = rd; v.ld = ld; v.mdu = mdu; v.rdr = rdr; v.rpc = rpc; v.mb = mb;
    v.tr = tr; v.tv = tv; v.e_stall = es; v.e_bubble = eb; v.e_redir = er; v.e_pc = epc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic idle_inputs();
    fetch_i_busy = 0; dec_i_rs1 = 0; dec_i_rs2 = 0; dec_i_use_rs1 = 0; dec_i_use_rs2 = 0;
    exe_i_rd = 0; exe_i_is_load = 0; exe_i_mdu_busy = 0; exe_i_redirect = 0;
    exe_i_redirect_pc = 0; mem_i_busy = 0; wb_i_trap = 0; wb_i_trap_vec = 0; wb_i_ebreak = 0;
  endtask

  task automatic apply(input vec_t v);
    fetch_i_busy = v.fb; dec_i_rs1 = v.rs1; dec_i_rs2 = v.rs2;
    dec_i_use_rs1 = v.u1; dec_i_use_rs2 = v.u2; exe_i_rd = v.rd;
    exe_i_is_load = v.ld; exe_i_mdu_busy = v.mdu; exe_i_redirect = v.rdr;
    exe_i_redirect_pc = v.rpc; mem_i_busy = v.mb; wb_i_trap = v.tr;
    wb_i_trap_vec = v.tv; wb_i_ebreak = 0;
  endtask

  task automatic chk_ctl(input string nm, input logic [3:0] es, input logic [3:0] eb,
                         input logic er);
    chk({nm, ".stall"},  {60'd0, stall_f, stall_d, stall_e, stall_m}, {60'd0, es});
    chk({nm, ".bubble"}, {60'd0, bubble_d, bubble_e, bubble_m, bubble_w}, {60'd0, eb});
    chk({nm, ".redir"},  {63'd0, redirect}, {63'd0, er});
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 0;
    #1;
    chk_ctl("rst", 4'b0000, 4'b0000, 1'b0);
    chk("rst.halted", {63'd0, halted}, 64'd0);
    chk("rst.cnt_mem", {32'd0, cnt_mem}, 64'd0);
    chk("rst.cnt_hazard", {32'd0, cnt_hazard}, 64'd0);
    chk("rst.cnt_flush", {32'd0, cnt_flush}, 64'd0);
    @(negedge clk);
    rst = 1;
  endtask

  initial begin
    rst = 0;
    idle_inputs();
    //          name       fb rs1 rs2 u1 u2 rd ld mdu rdr rpc            mb tr tv             stall    bubble   er pc
    vecs.push_back(mk("idle",    0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h0,         0, 0, 64'h0,         4'b0000, 4'b0000, 0, 64'h0));
    vecs.push_back(mk("lu_rs2",  0, 3, 5, 0, 1, 5, 1, 0, 0, 64'h0,         0, 0, 64'h0,         4'b1100, 4'b0100, 0, 64'h0));
    vecs.push_back(mk("lu_x0",   0, 0, 0, 1, 1, 0, 1, 0, 0, 64'h0,         0, 0, 64'h0,         4'b0000, 4'b0000, 0, 64'h0));
    vecs.push_back(mk("lu_nouse",0, 7, 2, 0, 1, 7, 1, 0, 0, 64'h0,         0, 0, 64'h0,         4'b0000, 4'b0000, 0, 64'h0));
    vecs.push_back(mk("lu_rs1",  0, 7, 2, 1, 0, 7, 1, 0, 0, 64'h0,         0, 0, 64'h0,         4'b1100, 4'b0100, 0, 64'h0));
    vecs.push_back(mk("redir_lu",0, 5, 5, 1, 1, 5, 1, 0, 1, 64'h8000_0040, 0, 0, 64'h0,         4'b0000, 4'b1100, 1, 64'h8000_0040));
    vecs.push_back(mk("mem_mdu", 0, 0, 0, 0, 0, 0, 0, 1, 0, 64'h0,         1, 0, 64'h0,         4'b1111, 4'b0001, 0, 64'h0));
    vecs.push_back(mk("mdu",     0, 0, 0, 0, 0, 0, 0, 1, 0, 64'h0,         0, 0, 64'h0,         4'b1110, 4'b0010, 0, 64'h0));
    vecs.push_back(mk("fbusy",   1, 0, 0, 0, 0, 0, 0, 0, 0, 64'h0,         0, 0, 64'h0,         4'b0000, 4'b1000, 0, 64'h0));
    vecs.push_back(mk("trap",    1, 0, 0, 0, 0, 0, 0, 1, 1, 64'h1234,      0, 1, 64'h8000_0200, 4'b0000, 4'b1111, 1, 64'h8000_0200));
    vecs.push_back(mk("mdu_rdr", 0, 0, 0, 0, 0, 0, 0, 1, 1, 64'h44,        0, 0, 64'h0,         4'b1110, 4'b0010, 0, 64'h0));
    vecs.push_back(mk("rdr_fb",  1, 0, 0, 0, 0, 0, 0, 0, 1, 64'hFFFF_0000_0000_0008, 0, 0, 64'h0, 4'b0000, 4'b1100, 1, 64'hFFFF_0000_0000_0008));
    vecs.push_back(mk("noload",  0, 9, 9, 1, 1, 9, 0, 0, 0, 64'h0,         0, 0, 64'h0,         4'b0000, 4'b0000, 0, 64'h0));
    vecs.push_back(mk("mem_rdr", 0, 5, 5, 1, 1, 5, 1, 0, 1, 64'h88,        1, 0, 64'h0,         4'b1111, 4'b0001, 0, 64'h0));

    do_reset();

    // Table: each vector lasts one cycle; counters checked once afterwards.
    foreach (vecs[i]) begin
      @(negedge clk);
      apply(vecs[i]);
      #1;
      chk_ctl(vecs[i].nm, vecs[i].e_stall, vecs[i].e_bubble, vecs[i].e_redir);
      if (vecs[i].e_redir) chk({vecs[i].nm, ".pc"}, redirect_pc, vecs[i].e_pc);
      chk({vecs[i].nm, ".halted"}, {63'd0, halted}, 64'd0);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    chk("tbl.cnt_mem", {32'd0, cnt_mem}, 64'd2);
    chk("tbl.cnt_hazard", {32'd0, cnt_hazard}, 64'd4);
    chk("tbl.cnt_flush", {32'd0, cnt_flush}, 64'd3);

    // Memory busy 3 cycles, then a trap that must drain behind memory.
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      mem_i_busy = 1;
      #1;
      chk_ctl("memwait", 4'b1111, 4'b0001, 1'b0);
    end
    @(negedge clk);
    wb_i_trap = 1; wb_i_trap_vec = 64'h8000_0100;
    #1;
    chk_ctl("trap_busy", 4'b1000, 4'b1111, 1'b0);
    @(negedge clk);
    // In DRAIN everything but mem_i_busy is noise.
    wb_i_trap = 1; wb_i_trap_vec = 64'hDEAD; exe_i_redirect = 1; exe_i_redirect_pc = 64'h77;
    exe_i_mdu_busy = 1;
    #1;
    chk_ctl("drain_busy", 4'b1000, 4'b1111, 1'b0);
    @(negedge clk);
    mem_i_busy = 0;
    #1;
    chk_ctl("drain_rel", 4'b1000, 4'b1111, 1'b1);
    chk("drain_rel.pc", redirect_pc, 64'h8000_0100);
    @(negedge clk);
    idle_inputs();
    #1;
    chk_ctl("post_drain", 4'b0000, 4'b0000, 1'b0);
    chk("drain.cnt_mem", {32'd0, cnt_mem}, 64'd3);
    chk("drain.cnt_flush", {32'd0, cnt_flush}, 64'd1);
    chk("drain.cnt_hazard", {32'd0, cnt_hazard}, 64'd0);

    // Reset in the middle of DRAIN returns straight to RUN.
    @(negedge clk);
    mem_i_busy = 1; wb_i_trap = 1; wb_i_trap_vec = 64'h99;
    @(negedge clk);
    wb_i_trap = 0;
    #1;
    chk_ctl("drain2", 4'b1000, 4'b1111, 1'b0);
    do_reset();

    // ebreak: halted the following cycle and sticky under random inputs.
    @(negedge clk);
    wb_i_ebreak = 1;
    #1;
    chk_ctl("ebreak", 4'b1000, 4'b1111, 1'b0);
    chk("ebreak.halted_now", {63'd0, halted}, 64'd0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      fetch_i_busy = 1'($urandom); dec_i_rs1 = 5'($urandom); dec_i_rs2 = 5'($urandom);
      dec_i_use_rs1 = 1'($urandom); dec_i_use_rs2 = 1'($urandom); exe_i_rd = 5'($urandom);
      exe_i_is_load = 1'($urandom); exe_i_mdu_busy = 1'($urandom);
      exe_i_redirect = 1'($urandom); exe_i_redirect_pc = {$urandom, $urandom};
      mem_i_busy = 1'($urandom); wb_i_trap = 1'($urandom);
      wb_i_trap_vec = {$urandom, $urandom}; wb_i_ebreak = 1'($urandom);
      #1;
      chk("halt.halted", {63'd0, halted}, 64'd1);
      chk_ctl("halt", 4'b1000, 4'b1111, 1'b0);
    end
    chk("halt.cnt_mem", {32'd0, cnt_mem}, 64'd0);
    chk("halt.cnt_flush", {32'd0, cnt_flush}, 64'd0);
    // Asynchronous reset mid-cycle clears halt immediately.
    #2;
    idle_inputs();
    rst = 0;
    #1;
    chk("halt_rst.halted", {63'd0, halted}, 64'd0);
    chk_ctl("halt_rst", 4'b0000, 4'b0000, 1'b0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    #1;
    chk("after_rst.halted", {63'd0, halted}, 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
